pc_fetch_unit: RTL and testbench

Instruction-fetch initiator for the combinational instruction ROM (32-bit byte address A in, 32-bit word RD out, zero-latency read).
- Owns the PC, drives the ROM address every cycle and captures the returned word with its PC into a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush in-flight words.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush outranks push and pop.
// DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch initiator: owns the PC, reads the combinational ROM, buffers {pc, instr}.
// Build option FETCH_ALIGN_CHECK_EN turns misaligned redirects into a sticky stall fault.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            fetch_misalign
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_target;
  logic            fault_stall;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    head;
  fetch_entry_t    fetched;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  // Sticky until reset or a redirect to an aligned target.
  always_ff @(posedge clk) begin
    if (rst)                 misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= |redirect_pc[1:0];
  end

  assign redirect_target = redirect_pc;
  assign fault_stall     = misalign_q;
  assign fetch_misalign  = misalign_q;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign fault_stall     = 1'b0;
  assign fetch_misalign  = 1'b0;
`endif

  assign rom_addr  = pc;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign push      = fetch_en & ~redirect_valid & (~fifo_full | pop) & ~fault_stall;
  assign fetched   = '{pc: pc, instr: rom_rd};
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // NOTE: defaulting pc_next first keeps this block purely combinational (no latch).
  always_comb begin
    pc_next = pc;
    if (redirect_valid) pc_next = redirect_target;
    else if (push)      pc_next = pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (fetched),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy is tracked through full/empty; the raw count is not needed here.
  logic unused_count;
  assign unused_count = &{1'b0, fifo_count};

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed plan steps plus a random phase,
// all compared against a queue-based reference model of the fetch buffer.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_misalign;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_rd         (rom_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: each word holds its own word index.
  assign rom_rd = rom_addr >> 2;

  // Reference model: a queue of delivered-but-unconsumed words plus the PC.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  logic         m_fault = 1'b0;
  bit           m_pop;
  bit           m_push;

  always @(posedge clk) begin
    m_pop = (mq.size() != 0) && out_ready;
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc    = redirect_pc;
      m_fault = (redirect_pc % 4) != 0;
`else
      m_pc    = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      m_push = fetch_en && !m_fault && (mq.size() < FIFO_DEPTH || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back('{pc: m_pc, instr: m_pc / 4});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("model_rom_addr", rom_addr, m_pc);
    check("model_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("model_misalign", 32'(fetch_misalign), 32'(m_fault));
    if (mq.size() != 0) begin
      check("model_out_pc", out_pc, mq[0].pc);
      check("model_out_instr", out_instr, mq[0].instr);
    end
  endtask

  // One clock: inputs settle at the falling edge, outputs are compared there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    fetch_en = 1'b1; out_ready = 1'b1;
    step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pc", rom_addr, RESET_PC);
    check("reset_misalign", 32'(fetch_misalign), 32'd0);

    // Stream: one word per cycle once the first has arrived.
    rst = 1'b0;
    step();
    for (int k = 0; k < 256; k++) begin
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_instr", out_instr, 32'(k));
      check("stream_pc", out_pc, 32'(4 * k));
      step();
    end

    // Backpressure: buffer fills at two entries, PC parks at 0x8.
    rst = 1'b1; step();
    rst = 1'b0; out_ready = 1'b0; step();
    repeat (6) step();
    check("bp_rom_addr", rom_addr, 32'h8);
    check("bp_instr", out_instr, 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("bp_release_instr", out_instr, 32'(j));
      step();
    end

    // Redirect with a full buffer and a coincident ready.
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("redir_valid_low", 32'(out_valid), 32'd0);
    check("redir_rom_addr", rom_addr, 32'h40);
    step();
    check("redir_pc", out_pc, 32'h40);
    check("redir_instr", out_instr, 32'h10);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    check("wrap_instr0", out_instr, 32'h3FFF_FFFE);
    step();
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", out_pc, 32'h0000_0000);
    check("wrap_instr2", out_instr, 32'h0);

    // Reset while full.
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1; step();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_rom_addr", rom_addr, RESET_PC);
    step();
    check("midrst_pc", out_pc, RESET_PC);

    // Misaligned redirect.
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flag", 32'(fetch_misalign), 32'd1);
    check("mis_rom_addr", rom_addr, 32'h42);
    for (int c = 0; c < 10; c++) begin
      check("mis_stall_valid", 32'(out_valid), 32'd0);
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("mis_cleared", 32'(fetch_misalign), 32'd0);
    step();
    check("mis_recover_pc", out_pc, 32'h80);
    check("mis_recover_instr", out_instr, 32'h20);
`else
    check("mis_flag", 32'(fetch_misalign), 32'd0);
    check("mis_rom_addr", rom_addr, 32'h40);
    step();
    check("mis_pc", out_pc, 32'h40);
    check("mis_instr", out_instr, 32'h10);
`endif

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = $urandom_range(0, 1) != 0;
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
